// File: rtl/tdp_ram_pkg.sv
// Shared defaults and types for the arbitrated true-dual-port RAM.
package tdp_ram_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_STARVE_LIM = 2;

    // Which port wins a same-address conflict.
    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

endpackage

// File: rtl/tdp_ram_core.sv
// Two independent read/write ports onto one word array. No arbitration here:
// the caller guarantees both ports never write the same word in one cycle.
module tdp_ram_core #(
    parameter int WIDTH  = tdp_ram_pkg::DEF_WIDTH,
    parameter int DEPTH  = tdp_ram_pkg::DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  wdata_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  wdata_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             in_range_a;
    logic             in_range_b;

    // Addresses past the last word (only possible for non-power-of-two DEPTH)
    // are ignored on write and read back as zero.
    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
        assign in_range_a = 1'b1;
        assign in_range_b = 1'b1;
    end else begin : g_npow2
        localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
        assign in_range_a = ({1'b0, addr_a} < DEPTH_L);
        assign in_range_b = ({1'b0, addr_b} < DEPTH_L);
    end

    // Word writes from either port.
    // NOTE: the array has no reset branch on purpose; contents survive reset
    // and a resettable array could not map onto RAM macros.
    always_ff @(posedge clk) begin
        if (we_a && in_range_a) mem[addr_a] <= wdata_a;
        if (we_b && in_range_b) mem[addr_b] <= wdata_b;
    end

    assign rdata_a = in_range_a ? mem[addr_a] : '0;
    assign rdata_b = in_range_b ? mem[addr_b] : '0;

endmodule

// File: rtl/tdp_ram_arbiter.sv
// Dual-port RAM front end: grants both ports unless they collide on one word
// with at least one write, then grants the priority holder. Port B gains
// priority after STARVE_LIM consecutive conflict denials.
module tdp_ram_arbiter
    import tdp_ram_pkg::*;
#(
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int STARVE_LIM = DEF_STARVE_LIM,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  data_a,
    output logic              ack_a,
    output logic [WIDTH-1:0]  q_a,
    output logic              q_valid_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  data_b,
    output logic              ack_b,
    output logic [WIDTH-1:0]  q_b,
    output logic              q_valid_b,
    output logic [15:0]       conflict_cnt
);

    localparam int                  STARVE_W   = $clog2(STARVE_LIM + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    prio_e               prio;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic [15:0]         conflict_cnt_q;
    logic                conflict;
    logic                b_denied;
    logic [WIDTH-1:0]    rdata_a;
    logic [WIDTH-1:0]    rdata_b;

    // Grant decision; reset masks both grants so nothing is written.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        conflict   = 1'b0;
        ack_a      = 1'b0;
        ack_b      = 1'b0;
        b_denied   = 1'b0;
        starve_nxt = starve_cnt;
        conflict   = req_a && req_b && (addr_a == addr_b) && (we_a || we_b);
        if (!rst) begin
            ack_a = req_a && (!conflict || prio == PRIO_A);
            ack_b = req_b && (!conflict || prio == PRIO_B);
        end
        b_denied = conflict && (prio == PRIO_A);
        if (starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + 1'b1;
    end

    // Priority and starvation tracking for port B.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= PRIO_A;
            starve_cnt <= '0;
        end else if (ack_b) begin
            prio       <= PRIO_A;
            starve_cnt <= '0;
        end else if (b_denied) begin
            starve_cnt <= starve_nxt;
            if (starve_nxt == STARVE_MAX) prio <= PRIO_B;
        end
    end

    // Saturating count of conflict cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else if (conflict && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_q;

    // Read-data registers; q holds across writes and idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a       <= '0;
            q_b       <= '0;
            q_valid_a <= 1'b0;
            q_valid_b <= 1'b0;
        end else begin
            q_valid_a <= ack_a && !we_a;
            q_valid_b <= ack_b && !we_b;
            if (ack_a && !we_a) q_a <= rdata_a;
            if (ack_b && !we_b) q_b <= rdata_b;
        end
    end

    tdp_ram_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .we_a    (ack_a && we_a),
        .addr_a  (addr_a),
        .wdata_a (data_a),
        .rdata_a (rdata_a),
        .we_b    (ack_b && we_b),
        .addr_b  (addr_b),
        .wdata_b (data_b),
        .rdata_b (rdata_b)
    );

endmodule

// File: tb/tb_tdp_ram_arbiter.sv
// Directed bench for tdp_ram_arbiter with default parameters.
module tb_tdp_ram_arbiter;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [WIDTH-1:0]  data_a, data_b;
    logic              ack_a, ack_b, q_valid_a, q_valid_b;
    logic [WIDTH-1:0]  q_a, q_b;
    logic [15:0]       conflict_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tdp_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIM(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_a        (req_a),
        .we_a         (we_a),
        .addr_a       (addr_a),
        .data_a       (data_a),
        .ack_a        (ack_a),
        .q_a          (q_a),
        .q_valid_a    (q_valid_a),
        .req_b        (req_b),
        .we_b         (we_b),
        .addr_b       (addr_b),
        .data_b       (data_b),
        .ack_b        (ack_b),
        .q_b          (q_b),
        .q_valid_b    (q_valid_b),
        .conflict_cnt (conflict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_a(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [WIDTH-1:0] d);
        req_a = r; we_a = w; addr_a = a; data_a = d;
    endtask

    task automatic drive_b(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [WIDTH-1:0] d);
        req_b = r; we_b = w; addr_b = a; data_b = d;
    endtask

    task automatic idle();
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Requests during reset must be refused.
        drive_a(1'b1, 1'b1, 6'd3, 8'hFF);
        drive_b(1'b1, 1'b0, 6'd4, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_q_a", q_a, 0);
        check("rst_q_b", q_b, 0);
        check("rst_qv_a", q_valid_a, 0);
        check("rst_qv_b", q_valid_b, 0);
        check("rst_cnt", conflict_cnt, 0);

        // Write then read on port A, first request right after release.
        @(negedge clk);
        rst = 1'b0;
        idle();
        drive_a(1'b1, 1'b1, 6'd3, 8'hA5);
        #1 check("wr3_ack_a", ack_a, 1);
        tick();
        check("wr3_qv_a", q_valid_a, 0);
        @(negedge clk);
        drive_a(1'b1, 1'b0, 6'd3, 8'h00);
        #1 check("rd3_ack_a", ack_a, 1);
        tick();
        check("rd3_q_a", q_a, 8'hA5);
        check("rd3_qv_a", q_valid_a, 1);
        @(negedge clk);
        idle();
        tick();
        check("rd3_qv_drop", q_valid_a, 0);
        check("rd3_q_hold", q_a, 8'hA5);

        // Independent writes on both ports, then crossed reads.
        @(negedge clk);
        drive_a(1'b1, 1'b1, 6'd5, 8'h11);
        drive_b(1'b1, 1'b1, 6'd9, 8'h22);
        #1 check("wr59_ack_a", ack_a, 1);
        check("wr59_ack_b", ack_b, 1);
        tick();
        @(negedge clk);
        drive_a(1'b1, 1'b0, 6'd9, 8'h00);
        drive_b(1'b1, 1'b0, 6'd5, 8'h00);
        tick();
        check("rd9_q_a", q_a, 8'h22);
        check("rd5_q_b", q_b, 8'h11);
        check("rd59_qv_b", q_valid_b, 1);
        check("wr59_cnt", conflict_cnt, 0);

        // Same-address read/read is not a conflict.
        @(negedge clk);
        idle();
        drive_a(1'b1, 1'b1, 6'd12, 8'h3C);
        tick();
        @(negedge clk);
        drive_a(1'b1, 1'b0, 6'd12, 8'h00);
        drive_b(1'b1, 1'b0, 6'd12, 8'h00);
        #1 check("rr12_ack_a", ack_a, 1);
        check("rr12_ack_b", ack_b, 1);
        tick();
        check("rr12_q_a", q_a, 8'h3C);
        check("rr12_q_b", q_b, 8'h3C);
        check("rr12_cnt", conflict_cnt, 0);

        // Write/write conflict on addr 7; A stops after two grants.
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            drive_a(1'b1, 1'b1, 6'd7, 8'h33);
            drive_b(1'b1, 1'b1, 6'd7, 8'h44);
            #1 check($sformatf("ww7_c%0d_ack_a", c), ack_a, 1);
            check($sformatf("ww7_c%0d_ack_b", c), ack_b, 0);
            tick();
        end
        @(negedge clk);
        drive_a(1'b0, 1'b0, '0, '0);
        #1 check("ww7_c3_ack_b", ack_b, 1);
        tick();
        check("ww7_cnt", conflict_cnt, 2);

        // Persistent conflict on addr 8: A, A, B (after flip), A again.
        @(negedge clk);
        drive_a(1'b1, 1'b1, 6'd8, 8'h55);
        drive_b(1'b1, 1'b1, 6'd8, 8'h66);
        for (int c = 1; c <= 4; c++) begin
            #1 check($sformatf("ww8_c%0d_ack_a", c), ack_a, (c == 3) ? 0 : 1);
            check($sformatf("ww8_c%0d_ack_b", c), ack_b, (c == 3) ? 1 : 0);
            tick();
            @(negedge clk);
        end
        drive_a(1'b1, 1'b0, 6'd7, 8'h00);
        drive_b(1'b1, 1'b0, 6'd8, 8'h00);
        tick();
        check("rd7_q_a", q_a, 8'h44);
        check("rd8_q_b", q_b, 8'h55);
        check("ww8_cnt", conflict_cnt, 6);

        // Read/write conflict: A reads old data, B waits then writes.
        @(negedge clk);
        drive_a(1'b1, 1'b0, 6'd8, 8'h00);
        drive_b(1'b1, 1'b1, 6'd8, 8'h77);
        #1 check("rw8_ack_a", ack_a, 1);
        check("rw8_ack_b", ack_b, 0);
        tick();
        check("rw8_q_a", q_a, 8'h55);
        check("rw8_cnt", conflict_cnt, 7);
        @(negedge clk);
        drive_a(1'b0, 1'b0, '0, '0);
        #1 check("rw8_late_ack_b", ack_b, 1);
        tick();
        @(negedge clk);
        idle();
        drive_a(1'b1, 1'b0, 6'd8, 8'h00);
        tick();
        check("rd8_new_q_a", q_a, 8'h77);

        // Reset right after an accepted read drops it; memory survives.
        @(negedge clk);
        drive_a(1'b1, 1'b1, 6'd20, 8'h5A);
        tick();
        @(negedge clk);
        drive_a(1'b1, 1'b0, 6'd20, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("mid_rst_qv_a", q_valid_a, 0);
        check("mid_rst_q_a", q_a, 0);
        check("mid_rst_cnt", conflict_cnt, 0);
        @(negedge clk);
        drive_a(1'b1, 1'b1, 6'd20, 8'hFF);
        drive_b(1'b1, 1'b1, 6'd21, 8'hEE);
        #1 check("mid_rst_ack_a", ack_a, 0);
        check("mid_rst_ack_b", ack_b, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        tick();
        check("post_rst_qv_a", q_valid_a, 0);
        @(negedge clk);
        drive_a(1'b1, 1'b0, 6'd20, 8'h00);
        tick();
        check("post_rst_rd20", q_a, 8'h5A);
        check("post_rst_qv_a2", q_valid_a, 1);

        // Counter saturation.
        @(negedge clk);
        force dut.conflict_cnt_q = 16'hFFFE;
        #1 release dut.conflict_cnt_q;
        check("sat_preset", conflict_cnt, 16'hFFFE);
        drive_a(1'b1, 1'b1, 6'd30, 8'h01);
        drive_b(1'b1, 1'b1, 6'd30, 8'h02);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("sat_c%0d", c), conflict_cnt, 16'hFFFF);
        end
        @(negedge clk);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdp_ram_arbiter.md
TDP_RAM_ARBITER -- requirements
Module: tdp_ram_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 64, number of words; ADDR_W = $clog2(DEPTH).
REQ-003 Parameter STARVE_LIM, default 2, consecutive port-B denials before priority flips to B.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_a / req_b  input  1  port request valid.
REQ-007 we_a / we_b  input  1  1 = write, 0 = read; qualified by req_x.
REQ-008 addr_a / addr_b  input  ADDR_W  word address.
REQ-009 data_a / data_b  input  WIDTH  write data.
REQ-010 ack_a / ack_b  output  1  combinational grant; request accepted at the posedge where req_x && ack_x.
REQ-011 q_a / q_b  output  WIDTH  registered read data.
REQ-012 q_valid_a / q_valid_b  output  1  one-cycle pulse marking q_x valid.
REQ-013 conflict_cnt  output  16  saturating count of arbitrated conflicts.

Function
REQ-014 Conflict SHALL be req_a && req_b && addr_a == addr_b && (we_a || we_b); same-address read/read is not a conflict.
REQ-015 Without conflict, ack_x SHALL equal req_x for both ports; both ports served in the same cycle.
REQ-016 On conflict, exactly one ack SHALL assert: the port holding priority (prio); the other sees ack = 0 and must hold its request.
REQ-017 prio SHALL reset to A; starve counter increments on each cycle B is denied by conflict, clears when B is accepted.
REQ-018 When starve counter reaches STARVE_LIM, prio SHALL become B; prio returns to A on the cycle after B is accepted.
REQ-019 Accepted write SHALL update memory at that posedge; q_x and q_valid_x unaffected (q_x holds).
REQ-020 Accepted read SHALL return data one cycle later: q_x loaded at the accepting posedge, q_valid_x high for exactly the following cycle.
REQ-021 Read of an address written by the other port in the same cycle cannot occur (conflict rule); read-after-write to same address on a later cycle SHALL return new data.
REQ-022 conflict_cnt SHALL increment by 1 per conflict cycle, saturate at 16'hFFFF, never wrap.
REQ-023 While rst is high, ack_a = ack_b = 0 and no memory write SHALL occur.
REQ-024 Addresses are always in range (ADDR_W exact for power-of-two DEPTH); for non-power-of-two DEPTH, requests with addr >= DEPTH SHALL be acked but ignored (read returns 0).

Reset
REQ-025 On rst: q_a = q_b = 0, q_valid_a = q_valid_b = 0, prio = A, starve counter = 0, conflict_cnt = 0.
REQ-026 Reset asserted mid-operation SHALL drop any in-flight read (no q_valid pulse after release).
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 First request SHALL be accepted in the first clock edge after rst deasserts.

Structure
REQ-029 Package tdp_ram_pkg SHALL hold default WIDTH, DEPTH, STARVE_LIM, and enum prio_e {PRIO_A, PRIO_B}.
REQ-030 Storage SHALL be sub-module tdp_ram_core (two independent read/write ports, no arbitration); arbitration, counters and output registers stay in tdp_ram_arbiter.

Verification
REQ-031 Port A write 8'hA5 to addr 3, next cycle read addr 3 -> ack_a both cycles, q_a = 8'hA5 with q_valid_a one cycle after read.
REQ-032 Simultaneous write A addr 5 = 8'h11, write B addr 9 = 8'h22 -> both acked same cycle, later reads return 8'h11 / 8'h22, conflict_cnt = 0.
REQ-033 Both write addr 7 (A = 8'h33, B = 8'h44) held for 3 cycles -> ack_a cycle 1-2, ack_b denied cycles 1-2, ack_b cycle 3 after prio flip, final mem[7] = 8'h44, conflict_cnt = 2.
REQ-034 Both read addr 12 same cycle -> both acked, q_a = q_b = mem[12], conflict_cnt unchanged.
REQ-035 Assert rst one cycle after an accepted read -> no q_valid pulse, q = 0, conflict_cnt = 0, previously written mem data still readable after release.
REQ-036 Force conflict_cnt to 16'hFFFE, create 3 conflicts -> conflict_cnt stays 16'hFFFF.
